// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared constants and types for the cache<->memory bus (A2/D2/C2)
//
// Contents:
//   C2_* command/response codes, line and bus geometry, line_t/beat_t types,
//   mem_state_t controller states.

package mem_bus_pkg;

  localparam int LINE_BYTES     = 16;
  localparam int OFFSET_SIZE    = 4;
  localparam int ADDR2_BUS_SIZE = 14;
  localparam int DATA2_BUS_SIZE = 16;
  localparam int CTR2_BUS_SIZE  = 2;
  localparam int MEM_SIZE       = 1 << (ADDR2_BUS_SIZE + OFFSET_SIZE);
  localparam int LINE_BITS      = LINE_BYTES * 8;
  localparam int LINE_BEATS     = LINE_BITS / DATA2_BUS_SIZE;
  // Beat index needs at least one bit even for a single-beat line.
  localparam int BEAT_W         = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;

  localparam logic [CTR2_BUS_SIZE-1:0] C2_NOP        = 2'd0;
  localparam logic [CTR2_BUS_SIZE-1:0] C2_RESPONSE   = 2'd1;
  localparam logic [CTR2_BUS_SIZE-1:0] C2_READ_LINE  = 2'd2;
  localparam logic [CTR2_BUS_SIZE-1:0] C2_WRITE_LINE = 2'd3;

  typedef logic [LINE_BITS-1:0]      line_t;
  typedef logic [DATA2_BUS_SIZE-1:0] beat_t;

  typedef enum logic [1:0] {IDLE, RECV, WAIT, SEND} mem_state_t;

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - byte-addressed backing storage with whole-line read and write ports
//
// Ports:
//   i_clk      in   clock for the write port
//   i_rd_addr  in   line address for the combinational read port
//   o_rd_line  out  line at i_rd_addr, byte 0 in bits [7:0]
//   i_we       in   write the whole line at i_wr_addr on the clock edge
//   i_wr_addr  in   line address for the write port
//   i_wr_line  in   line data to store, byte 0 in bits [7:0]
// Contents start at zero and are never cleared by reset.

module mem_array
  import mem_bus_pkg::*;
(
  input  logic                      i_clk,
  input  logic [ADDR2_BUS_SIZE-1:0] i_rd_addr,
  output line_t                     o_rd_line,
  input  logic                      i_we,
  input  logic [ADDR2_BUS_SIZE-1:0] i_wr_addr,
  input  line_t                     i_wr_line
);

  logic [7:0] r_mem [MEM_SIZE] = '{default: 8'h00};

  always_comb begin
    o_rd_line = '0;
    for (int b = 0; b < LINE_BYTES; b++) begin
      o_rd_line[8*b +: 8] = r_mem[{i_rd_addr, OFFSET_SIZE'(b)}];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < LINE_BYTES; b++) begin
        r_mem[{i_wr_addr, OFFSET_SIZE'(b)}] <= i_wr_line[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - backing-store memory controller serving READ_LINE/WRITE_LINE with fixed latency
//
// Ports:
//   CLK       in     clock, all state on posedge
//   RESET     in     asynchronous active-low reset
//   A2        in     line address, sampled with the command
//   D2        inout  16-bit line beats, beat0 = bytes 0..1 little-endian
//   C2        inout  NOP/RESPONSE/READ_LINE/WRITE_LINE
//   RD_COUNT  out    completed reads  (only with MEM_CTRL_STATS_EN)
//   WR_COUNT  out    completed writes (only with MEM_CTRL_STATS_EN)
// Optional feature macro: MEM_CTRL_STATS_EN adds saturating completion counters.
// C2/D2 are driven only in SEND; high-Z otherwise.

module mem_ctrl
  import mem_bus_pkg::*;
#(
  parameter int MEM_DELAY = 100
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [ADDR2_BUS_SIZE-1:0] A2,
  inout  wire  [DATA2_BUS_SIZE-1:0] D2,
  inout  wire  [CTR2_BUS_SIZE-1:0]  C2
`ifdef MEM_CTRL_STATS_EN
  ,
  output logic [31:0]               RD_COUNT,
  output logic [31:0]               WR_COUNT
`endif
);

  localparam int                CNT_W     = $clog2(MEM_DELAY + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(MEM_DELAY - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(LINE_BEATS - 1);

  mem_state_t                r_state;
  logic                      r_op_wr;
  logic [ADDR2_BUS_SIZE-1:0] r_addr;
  logic [BEAT_W-1:0]         r_idx;
  logic [CNT_W-1:0]          r_cnt;
  line_t                     r_shift;
  logic                      r_oe;

  line_t                     w_rd_line;
  line_t                     w_shift_in;
  logic                      w_we;
  logic                      w_cmd_rd;
  logic                      w_cmd_wr;

  // Incoming beats enter at the top so that after a full line beat0 sits in
  // bits [15:0]; the same register later shifts right to present read beats.
  generate
    if (LINE_BEATS > 1) begin : g_multi_beat
      assign w_shift_in = {D2, r_shift[LINE_BITS-1:DATA2_BUS_SIZE]};
    end else begin : g_single_beat
      assign w_shift_in = D2;
    end
  endgenerate

  assign w_cmd_rd = (r_state == IDLE) && (C2 == C2_READ_LINE);
  assign w_cmd_wr = (r_state == IDLE) && (C2 == C2_WRITE_LINE);

  // The line commits on the edge its last beat is sampled, so a write that is
  // cut short by reset never reaches storage.
  assign w_we = (LINE_BEATS > 1) ? ((r_state == RECV) && (r_idx == BEAT_LAST))
                                 : w_cmd_wr;

  mem_array u_mem_array (
    .i_clk     (CLK),
    .i_rd_addr (r_addr),
    .o_rd_line (w_rd_line),
    .i_we      (w_we),
    .i_wr_addr ((r_state == IDLE) ? A2 : r_addr),
    .i_wr_line (w_shift_in)
  );

  assign C2 = r_oe ? C2_RESPONSE : {CTR2_BUS_SIZE{1'bz}};
  assign D2 = r_oe ? r_shift[DATA2_BUS_SIZE-1:0] : {DATA2_BUS_SIZE{1'bz}};

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= IDLE;
      r_op_wr <= 1'b0;
      r_addr  <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_shift <= '0;
      r_oe    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_cmd_rd) begin
            r_addr  <= A2;
            r_op_wr <= 1'b0;
            r_cnt   <= CNT_LOAD;
            r_state <= WAIT;
          end else if (w_cmd_wr) begin
            r_addr  <= A2;
            r_op_wr <= 1'b1;
            r_shift <= w_shift_in;
            if (LINE_BEATS > 1) begin
              r_idx   <= BEAT_W'(1);
              r_state <= RECV;
            end else begin
              r_cnt   <= CNT_LOAD;
              r_state <= WAIT;
            end
          end
        end
        RECV: begin
          r_shift <= w_shift_in;
          if (r_idx == BEAT_LAST) begin
            r_cnt   <= CNT_LOAD;
            r_state <= WAIT;
          end else begin
            r_idx <= r_idx + BEAT_W'(1);
          end
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_state <= SEND;
            r_oe    <= 1'b1;
            r_idx   <= '0;
            // A write acknowledges with an all-zero data beat.
            r_shift <= r_op_wr ? '0 : w_rd_line;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        SEND: begin
          if (r_op_wr || (r_idx == BEAT_LAST)) begin
            r_oe    <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_idx   <= r_idx + BEAT_W'(1);
            r_shift <= r_shift >> DATA2_BUS_SIZE;
          end
        end
        default: begin
          r_oe    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef MEM_CTRL_STATS_EN
  logic [31:0] r_rd_count;
  logic [31:0] r_wr_count;
  logic        w_send_done;

  assign w_send_done = (r_state == SEND) && (r_op_wr || (r_idx == BEAT_LAST));

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else if (w_send_done) begin
      if (!r_op_wr && (r_rd_count != 32'hFFFF_FFFF)) begin
        r_rd_count <= r_rd_count + 32'd1;
      end
      if (r_op_wr && (r_wr_count != 32'hFFFF_FFFF)) begin
        r_wr_count <= r_wr_count + 32'd1;
      end
    end
  end

  assign RD_COUNT = r_rd_count;
  assign WR_COUNT = r_wr_count;
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - self-checking bench for mem_ctrl with a line-level reference model

module tb_mem_ctrl;
  import mem_bus_pkg::*;

  localparam int D  = 4;
  localparam int LB = LINE_BEATS;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] a2;
  tri1  [15:0] d2;
  tri0  [1:0]  c2;
  logic [15:0] tb_d2;
  logic        tb_d2_oe;
  logic [1:0]  tb_c2;
  logic        tb_c2_oe;

  int checks = 0;
  int errors = 0;
  int exp_rd = 0;
  int exp_wr = 0;

  logic [127:0] model_mem [logic [13:0]];

  assign d2 = tb_d2_oe ? tb_d2 : 16'hzzzz;
  assign c2 = tb_c2_oe ? tb_c2 : 2'bzz;

`ifdef MEM_CTRL_STATS_EN
  logic [31:0] rd_count;
  logic [31:0] wr_count;
`endif

  always #5 clk = ~clk;

  mem_ctrl #(.MEM_DELAY(D)) dut (
    .CLK      (clk),
    .RESET    (rst_n),
    .A2       (a2),
    .D2       (d2),
    .C2       (c2)
`ifdef MEM_CTRL_STATS_EN
    ,
    .RD_COUNT (rd_count),
    .WR_COUNT (wr_count)
`endif
  );

  function automatic logic [127:0] model_line(input logic [13:0] addr);
    if (model_mem.exists(addr)) return model_mem[addr];
    return 128'h0;
  endfunction

  function automatic logic [127:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full write transaction; checks bus every cycle until release.
  task automatic do_write(input logic [13:0] addr, input logic [127:0] line, input string tag);
    tb_c2 = C2_WRITE_LINE; tb_c2_oe = 1'b1; a2 = addr;
    tb_d2 = line[15:0]; tb_d2_oe = 1'b1;
    tick();
    tb_c2_oe = 1'b0;
    for (int j = 1; j <= LB + D; j++) begin
      if (j < LB) tb_d2 = line[16*j +: 16];
      else tb_d2_oe = 1'b0;
      tick();
      if (j == LB - 1 + D) begin
        checks++;
        if (c2 !== C2_RESPONSE || d2 !== 16'h0000) begin
          errors++;
          $display("FAIL %s wr_resp j=%0d: c2=%b d2=%h expected c2=%b d2=0000", tag, j, c2, d2, C2_RESPONSE);
        end
      end else begin
        checks++;
        if (c2 !== C2_NOP || (j >= LB && d2 !== 16'hFFFF)) begin
          errors++;
          $display("FAIL %s wr_idle j=%0d: c2=%b d2=%h expected released bus", tag, j, c2, d2);
        end
      end
    end
    model_mem[addr] = line;
    exp_wr++;
  endtask

  // Full read transaction; beats compared against the model line.
  task automatic do_read(input logic [13:0] addr, input string tag);
    logic [127:0] exp_line;
    exp_line = model_line(addr);
    tb_c2 = C2_READ_LINE; tb_c2_oe = 1'b1; a2 = addr;
    tick();
    tb_c2_oe = 1'b0;
    for (int j = 1; j <= D + LB; j++) begin
      tick();
      if (j >= D && j < D + LB) begin
        checks++;
        if (c2 !== C2_RESPONSE || d2 !== exp_line[16*(j-D) +: 16]) begin
          errors++;
          $display("FAIL %s rd_beat%0d: c2=%b d2=%h expected c2=%b d2=%h", tag, j - D, c2, d2,
                   C2_RESPONSE, exp_line[16*(j-D) +: 16]);
        end
      end else begin
        checks++;
        if (c2 !== C2_NOP || d2 !== 16'hFFFF) begin
          errors++;
          $display("FAIL %s rd_idle j=%0d: c2=%b d2=%h expected released bus", tag, j, c2, d2);
        end
      end
    end
    exp_rd++;
  endtask

  task automatic test_reset();
    tick();
    checks++;
    if (c2 !== C2_NOP || d2 !== 16'hFFFF) begin
      errors++;
      $display("FAIL reset_bus: c2=%b d2=%h expected released bus", c2, d2);
    end
`ifdef MEM_CTRL_STATS_EN
    checks++;
    if (rd_count !== 32'd0 || wr_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_counts: rd=%0d wr=%0d expected 0 0", rd_count, wr_count);
    end
`endif
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (c2 !== C2_NOP) begin
      errors++;
      $display("FAIL reset_release: c2=%b expected %b", c2, C2_NOP);
    end
  endtask

  task automatic test_write_read();
    logic [127:0] line;
    for (int i = 0; i < LB; i++) line[16*i +: 16] = {8'(i + 1), 8'(i)};
    do_write(14'h0041, line, "wr_0041");
    do_read(14'h0041, "rd_0041");
  endtask

  task automatic test_unwritten();
    do_read(14'h3FFF, "rd_3fff");
  endtask

  task automatic test_busy();
    int resp;
    logic [127:0] l1;
    do_write(14'h0001, rand_line(), "busy_wr1");
    do_write(14'h0002, rand_line(), "busy_wr2");
    l1 = model_line(14'h0001);
    resp = 0;
    tb_c2 = C2_READ_LINE; tb_c2_oe = 1'b1; a2 = 14'h0001;
    tick();
    tb_c2_oe = 1'b0;
    for (int j = 1; j <= D + LB + 6; j++) begin
      if (j == 2) begin
        tb_c2 = C2_READ_LINE; tb_c2_oe = 1'b1; a2 = 14'h0001;
      end else if (j == 3) begin
        tb_c2 = C2_WRITE_LINE; a2 = 14'h0002; tb_d2 = 16'(~$urandom); tb_d2_oe = 1'b1;
      end else if (j == 4) begin
        tb_c2_oe = 1'b0; tb_d2_oe = 1'b0;
      end
      tick();
      if (c2 === C2_RESPONSE) begin
        if (resp < LB) begin
          checks++;
          if (d2 !== l1[16*resp +: 16]) begin
            errors++;
            $display("FAIL busy_beat%0d: d2=%h expected %h", resp, d2, l1[16*resp +: 16]);
          end
        end
        resp++;
      end
    end
    exp_rd++;
    checks++;
    if (resp != LB) begin
      errors++;
      $display("FAIL busy_bursts: response cycles=%0d expected %0d", resp, LB);
    end
    do_read(14'h0002, "busy_rd2");
  endtask

  task automatic test_reset_mid_recv();
    logic [127:0] newl;
    do_write(14'h0123, rand_line(), "rst_old");
    newl = rand_line();
    tb_c2 = C2_WRITE_LINE; tb_c2_oe = 1'b1; a2 = 14'h0123;
    tb_d2 = newl[15:0]; tb_d2_oe = 1'b1;
    tick();
    tb_c2_oe = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      tb_d2 = newl[16*j +: 16];
      tick();
    end
    tb_d2_oe = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (c2 !== C2_NOP || d2 !== 16'hFFFF) begin
      errors++;
      $display("FAIL recv_rst_bus: c2=%b d2=%h expected released bus", c2, d2);
    end
    tick(); tick();
    rst_n = 1'b1;
    exp_rd = 0; exp_wr = 0;
`ifdef MEM_CTRL_STATS_EN
    checks++;
    if (wr_count !== 32'd0) begin
      errors++;
      $display("FAIL recv_rst_wrcount: got %0d expected 0", wr_count);
    end
`endif
    tick();
    do_read(14'h0123, "recv_rst_read");
  endtask

  task automatic test_reset_mid_send();
    logic [127:0] l;
    l = model_line(14'h0123);
    tb_c2 = C2_READ_LINE; tb_c2_oe = 1'b1; a2 = 14'h0123;
    tick();
    tb_c2_oe = 1'b0;
    repeat (D + 2) tick();
    checks++;
    if (c2 !== C2_RESPONSE || d2 !== l[47:32]) begin
      errors++;
      $display("FAIL send_mid: c2=%b d2=%h expected c2=%b d2=%h", c2, d2, C2_RESPONSE, l[47:32]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (c2 !== C2_NOP || d2 !== 16'hFFFF) begin
      errors++;
      $display("FAIL send_rst_bus: c2=%b d2=%h expected released bus", c2, d2);
    end
    tick();
    rst_n = 1'b1;
    exp_rd = 0; exp_wr = 0;
    tick();
  endtask

  task automatic test_random();
    logic [13:0] addr;
    for (int n = 0; n < 16; n++) begin
      case ($urandom_range(0, 3))
        0: addr = 14'h0010;
        1: addr = 14'h0011;
        2: addr = 14'h0012;
        default: addr = 14'($urandom_range(0, 16'h3FFE));
      endcase
      if ($urandom_range(0, 1) == 1) do_write(addr, rand_line(), "rand_wr");
      else do_read(addr, "rand_rd");
    end
  endtask

`ifdef MEM_CTRL_STATS_EN
  task automatic test_stats();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_rd = 0; exp_wr = 0;
    tick();
    do_read(14'h0010, "st_rd0");
    do_write(14'h0020, rand_line(), "st_wr0");
    do_read(14'h0020, "st_rd1");
    do_write(14'h0021, rand_line(), "st_wr1");
    do_read(14'h0021, "st_rd2");
    checks++;
    if (rd_count !== 32'(exp_rd) || wr_count !== 32'(exp_wr)) begin
      errors++;
      $display("FAIL stats_counts: rd=%0d wr=%0d expected %0d %0d", rd_count, wr_count, exp_rd, exp_wr);
    end
    force dut.r_rd_count = 32'hFFFF_FFFF;
    tick();
    release dut.r_rd_count;
    do_read(14'h0020, "st_sat");
    checks++;
    if (rd_count !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL stats_saturate: rd=%h expected ffffffff", rd_count);
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    a2 = '0;
    tb_d2 = '0; tb_d2_oe = 1'b0;
    tb_c2 = C2_NOP; tb_c2_oe = 1'b0;
    test_reset();
    test_write_read();
    test_unwritten();
    test_busy();
    test_reset_mid_recv();
    test_reset_mid_send();
    test_random();
`ifdef MEM_CTRL_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
